// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks fetch PC, one outstanding ROM request, FWFT instruction FIFO; FETCH_STATS_EN adds counters.
// Latency: a ROM word is visible on instr_valid the cycle after rom_valid; min 3 cycles per instruction.
// Backpressure: instr_ready low fills the FIFO, then fetch stalls in FETCH until a slot frees.

// Generic FIFO with a registered head word that holds its last value when empty.
// Latency: push visible on head_vld_o/head_dat_o the next cycle; flush empties in one cycle.
// Backpressure: caller must not push when full_o; pop when empty is ignored.
module fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic             head_vld_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push, pop;

    assign push = push_vld_i && !flush_i;
    assign pop  = pop_rdy_i && (cnt_q != '0) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            // The head register tracks whichever entry will be at the front after this edge.
            if (pop) begin
                if (cnt_q == CW'(1)) begin
                    if (push) head_d = push_dat_i;
                end else begin
                    head_d = mem_q[rd_ptr_d];
                end
            end else if ((cnt_q == '0) && push) begin
                head_d = push_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_vld_o = (cnt_q != '0);
    assign head_dat_o = head_q;
    assign full_o     = (cnt_q == FULL_CNT);
endmodule

module instr_fetch_unit #(
    parameter int unsigned PC_WIDTH = 5,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_LIMIT = 6
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    output logic                rom_req,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic                rom_valid,
    input  logic [31:0]         rom_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
`ifdef FETCH_STATS_EN
    output logic [15:0]         stat_fetched,
    output logic [15:0]         stat_dropped,
`endif
    output logic                halted
);
    typedef enum logic [1:0] {FETCH, WAIT, HALT} state_t;

    localparam logic [PC_WIDTH-1:0] RST_PC = RESET_PC[PC_WIDTH-1:0];
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH:0]   LIMIT  = PC_LIMIT[PC_WIDTH:0];

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                discard_q, discard_d;
    logic                rom_req_q, rom_req_d;
    logic [PC_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                push, drop, at_limit, fifo_full;

    assign at_limit = ({1'b0, fetch_pc_q} >= LIMIT);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        rom_req_d  = 1'b0;
        rom_addr_d = rom_addr_q;
        push       = 1'b0;
        drop       = 1'b0;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            state_d    = FETCH;
            // An in-flight request cannot be cancelled: wait it out and throw the word away.
            if (state_q == WAIT) begin
                if (rom_valid) begin
                    drop      = 1'b1;
                    discard_d = 1'b0;
                end else begin
                    discard_d = 1'b1;
                    state_d   = WAIT;
                end
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (at_limit) begin
                        state_d = HALT;
                    end else if (!fifo_full) begin
                        rom_req_d  = 1'b1;
                        rom_addr_d = fetch_pc_q;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (rom_valid) begin
                        state_d = FETCH;
                        if (discard_q) begin
                            drop      = 1'b1;
                            discard_d = 1'b0;
                        end else begin
                            push       = 1'b1;
                            fetch_pc_d = fetch_pc_q + PC_ONE;
                        end
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RST_PC;
            discard_q  <= 1'b0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= RST_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    fifo #(
        .WIDTH (PC_WIDTH + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .flush_i    (redirect),
        .push_vld_i (push),
        .push_dat_i ({fetch_pc_q, rom_rdata}),
        .pop_rdy_i  (instr_ready),
        .head_vld_o (instr_valid),
        .head_dat_o ({instr_pc, instr}),
        .full_o     (fifo_full)
    );

    assign rom_req  = rom_req_q;
    assign rom_addr = rom_addr_q;
    assign halted   = at_limit && (state_q != WAIT);

`ifdef FETCH_STATS_EN
    logic [15:0] fetched_q, dropped_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (push && (fetched_q != 16'hFFFF)) fetched_q <= fetched_q + 16'd1;
            if (drop && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_dropped = dropped_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam int PW       = 5;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;
    localparam int LIMIT    = 6;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          rom_req;
    logic [PW-1:0] rom_addr;
    logic          rom_valid;
    logic [31:0]   rom_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [PW-1:0] instr_pc;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic          halted;
`ifdef FETCH_STATS_EN
    logic [15:0]   stat_fetched;
    logic [15:0]   stat_dropped;
`endif

    instr_fetch_unit #(
        .PC_WIDTH (PW),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_LIMIT (LIMIT)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_valid   (rom_valid),
        .rom_rdata   (rom_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef FETCH_STATS_EN
        .stat_fetched(stat_fetched),
        .stat_dropped(stat_dropped),
`endif
        .halted      (halted)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [31:0]   word;
    } ent_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of words the core should see, next PC to fetch, outstanding request.
    ent_t          exp_q[$];
    int            popped[$];
    logic [PW-1:0] exp_pc;
    bit            outstanding, killed;
    logic [PW-1:0] req_addr;
    int            rom_cnt, rom_lat, n_fetched, n_dropped;
    bit            lat_rand;

    bit            obs_req;
    logic [PW-1:0] obs_addr;
    bit            nx_ready, nx_redirect, nx_inject;
    logic [PW-1:0] nx_rpc;

    task automatic model_reset();
        exp_q.delete();
        exp_pc      = PW'(RESET_PC);
        outstanding = 0;
        killed      = 0;
        rom_cnt     = 0;
        n_fetched   = 0;
        n_dropped   = 0;
    endtask

    // One clock cycle, entered and left at a falling edge: check, drive ROM/core inputs, advance model.
    task automatic step();
        ent_t e;
        bit   exp_h;
        obs_req  = (rom_req === 1'b1);
        obs_addr = rom_addr;
        if (obs_req) begin
            checks++;
            if (outstanding || rom_addr !== exp_pc || int'(exp_pc) >= LIMIT || exp_q.size() >= DEPTH) begin
                failures++;
                $display("FAIL rom_req t=%0t addr=%0d exp_addr=%0d outstanding=%0b queued=%0d", $time, rom_addr, exp_pc, outstanding, exp_q.size());
            end
            outstanding = 1;
            killed      = 0;
            req_addr    = rom_addr;
        end
        checks++;
        if (instr_valid !== (exp_q.size() > 0)) begin
            failures++;
            $display("FAIL instr_valid t=%0t got=%0b exp=%0b", $time, instr_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            checks++;
            if (instr_pc !== exp_q[0].pc || instr !== exp_q[0].word) begin
                failures++;
                $display("FAIL head t=%0t got pc=%0d word=%h exp pc=%0d word=%h", $time, instr_pc, instr, exp_q[0].pc, exp_q[0].word);
            end
        end
        exp_h = (int'(exp_pc) >= LIMIT) && !outstanding;
        checks++;
        if (halted !== exp_h) begin
            failures++;
            $display("FAIL halted t=%0t got=%0b exp=%0b", $time, halted, exp_h);
        end

        rom_valid = 1'b0;
        if (nx_inject) begin
            rom_valid = 1'b1;
            rom_rdata = $urandom;
            nx_inject = 0;
        end else if (rom_cnt > 0) begin
            rom_cnt--;
            if (rom_cnt == 0) begin
                rom_valid = 1'b1;
                rom_rdata = 32'h00100093 + 32'(req_addr);
            end
        end
        if (obs_req) rom_cnt = lat_rand ? int'($urandom_range(1, 4)) : rom_lat;
        instr_ready = nx_ready;
        redirect    = nx_redirect;
        redirect_pc = nx_rpc;

        if (nx_redirect) begin
            exp_q.delete();
            if (outstanding) begin
                if (rom_valid) begin
                    n_dropped++;
                    outstanding = 0;
                end else begin
                    killed = 1;
                end
            end
            exp_pc = nx_rpc;
        end else begin
            if (exp_q.size() > 0 && nx_ready) begin
                popped.push_back(int'(exp_q[0].pc));
                void'(exp_q.pop_front());
            end
            if (rom_valid && outstanding) begin
                outstanding = 0;
                if (killed) begin
                    n_dropped++;
                end else begin
                    e.pc   = req_addr;
                    e.word = rom_rdata;
                    exp_q.push_back(e);
                    n_fetched++;
                    exp_pc = exp_pc + 5'd1;
                end
            end
        end
        nx_redirect = 0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        reset = 1'b1; rom_valid = 1'b0; rom_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        nx_ready = 0; nx_redirect = 0; nx_inject = 0; nx_rpc = '0; lat_rand = 0; rom_lat = 1;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (rom_req !== 1'b0 || rom_addr !== PW'(RESET_PC) || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got req=%b addr=%0d halted=%b exp 0/%0d/0", rom_req, rom_addr, halted, RESET_PC);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== '0) begin
            failures++;
            $display("FAIL reset_out got valid=%b instr=%h pc=%0d exp 0/0/0", instr_valid, instr, instr_pc);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        nx_ready = 1; rom_lat = 1; popped.delete();
        for (int i = 0; i < 100 && !(halted === 1'b1 && exp_q.size() == 0); i++) step();
        checks++;
        if (popped.size() != LIMIT || halted !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end got pops=%0d halted=%b valid=%b exp %0d/1/0", popped.size(), halted, instr_valid, LIMIT);
        end
        for (int i = 0; i < popped.size(); i++) begin
            checks++;
            if (popped[i] != i) begin
                failures++;
                $display("FAIL stream_order idx=%0d got pc=%0d exp=%0d", i, popped[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        int late_reqs = 0;
        int first_addr = -1;
        nx_ready = 0; rom_lat = 1; nx_redirect = 1; nx_rpc = '0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i >= 15 && obs_req) late_reqs++;
        end
        checks++;
        if (late_reqs != 0 || exp_q.size() != DEPTH || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall got late_reqs=%0d buffered=%0d valid=%b exp 0/%0d/1", late_reqs, exp_q.size(), instr_valid, DEPTH);
        end
        popped.delete();
        nx_ready = 1;
        for (int i = 0; i < 30 && (popped.size() < 4 || first_addr < 0); i++) begin
            step();
            if (obs_req && first_addr < 0) first_addr = int'(obs_addr);
        end
        checks++;
        if (first_addr != 4 || popped.size() < 4) begin
            failures++;
            $display("FAIL bp_resume got first_addr=%0d pops=%0d exp 4/>=4", first_addr, popped.size());
        end
        for (int i = 0; i < 4 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] != i) begin
                failures++;
                $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, popped[i], i);
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit hit = 0;
        nx_ready = 1; rom_lat = 3; nx_redirect = 1; nx_rpc = '0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            hit = obs_req && (obs_addr == 5'd1);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rw_setup got no request for pc 1, exp one within 40 cycles");
        end
        popped.delete();
        nx_redirect = 1; nx_rpc = 5'd2;
        step();
        for (int i = 0; i < 40 && popped.size() == 0; i++) step();
        checks++;
        if (popped.size() == 0 || popped[0] != 2) begin
            failures++;
            $display("FAIL rw_first got pops=%0d first=%0d exp first=2", popped.size(), popped.size() ? popped[0] : -1);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stat_dropped !== 16'(n_dropped)) begin
            failures++;
            $display("FAIL rw_stat_dropped got=%0d exp=%0d", stat_dropped, n_dropped);
        end
`endif
    endtask

    task automatic test_back_to_back_redirect();
        bit hit = 0;
        logic [PW-1:0] rpc;
        nx_ready = 0; rom_lat = 1; nx_redirect = 1; nx_rpc = '0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            hit = (rom_cnt == 1) && (exp_q.size() == 2);
        end
        checks++;
        if (!hit || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL col_setup got hit=%b valid=%b exp 1/1", hit, instr_valid);
        end
        rpc = PW'($urandom_range(0, LIMIT - 1));
        nx_ready = 1; nx_redirect = 1; nx_rpc = rpc;
        step();
        checks++;
        if (instr_valid !== 1'b0 || rom_req !== 1'b0) begin
            failures++;
            $display("FAIL col_flush got valid=%b req=%b exp 0/0", instr_valid, rom_req);
        end
        step();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== rpc) begin
            failures++;
            $display("FAIL col_refetch got req=%b addr=%0d exp 1/%0d", rom_req, rom_addr, rpc);
        end
    endtask

    task automatic test_halt_redirect();
        int reqs = 0;
        int lost_halt = 0;
        nx_ready = 1; rom_lat = 1;
        for (int i = 0; i < 100 && halted !== 1'b1; i++) step();
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL hr_halt got halted=%b exp 1", halted);
        end
        nx_redirect = 1; nx_rpc = 5'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_req) reqs++;
            if (halted !== 1'b1) lost_halt++;
        end
        checks++;
        if (reqs != 0 || lost_halt != 0) begin
            failures++;
            $display("FAIL hr_beyond got reqs=%0d unhalted_cycles=%0d exp 0/0", reqs, lost_halt);
        end
        nx_redirect = 1; nx_rpc = '0;
        reqs = 0;
        for (int i = 0; i < 10 && reqs == 0; i++) begin
            step();
            if (obs_req) reqs++;
        end
        checks++;
        if (reqs == 0 || obs_addr !== '0) begin
            failures++;
            $display("FAIL hr_restart got reqs=%0d addr=%0d exp 1/0", reqs, obs_addr);
        end
    endtask

    task automatic test_reset_midwait();
        bit hit = 0;
        nx_ready = 0; rom_lat = 3; nx_redirect = 1; nx_rpc = '0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            hit = (exp_q.size() == 3) && outstanding;
        end
        checks++;
        if (!hit || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_setup got hit=%b valid=%b exp 1/1", hit, instr_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || rom_req !== 1'b0) begin
            failures++;
            $display("FAIL rm_async got valid=%b req=%b exp 0/0", instr_valid, rom_req);
        end
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        nx_inject = 1; nx_ready = 1; rom_lat = 1;
        step();
        hit = 0;
        for (int i = 0; i < 6 && !hit; i++) begin
            step();
            hit = obs_req;
        end
        checks++;
        if (!hit || obs_addr !== PW'(RESET_PC)) begin
            failures++;
            $display("FAIL rm_first_req got seen=%b addr=%0d exp 1/%0d", hit, obs_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        popped.delete();
        lat_rand = 1;
        for (int i = 0; i < 500; i++) begin
            nx_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) begin
                nx_redirect = 1;
                nx_rpc = PW'($urandom_range(0, 7));
            end
            step();
        end
        checks++;
        if (popped.size() == 0) begin
            failures++;
            $display("FAIL rand_progress got pops=0 exp >0");
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stat_fetched !== 16'(n_fetched) || stat_dropped !== 16'(n_dropped)) begin
            failures++;
            $display("FAIL rand_stats got fetched=%0d dropped=%0d exp %0d/%0d", stat_fetched, stat_dropped, n_fetched, n_dropped);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_back_to_back_redirect();
        test_halt_redirect();
        test_reset_midwait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t exp finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
